// File: rtl/fifo_sc_param_pkg.sv
// Shared mode encodings and sizing helper for the single-clock FIFO.
package fifo_sc_param_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Pointers and the fill level carry one extra bit so depth itself is representable.
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_sc_ram.sv
// Simple dual-port RAM with registered, enabled read; no reset so it maps to block RAM.
module fifo_sc_ram #(
  parameter int dta_width  = 8,
  parameter int addr_width = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [dta_width-1:0]  wdata,
  input  logic                  re,
  input  logic [addr_width-1:0] raddr,
  output logic [dta_width-1:0]  rdata
);

  logic [dta_width-1:0] mem [0:(1<<addr_width)-1];

  // rdata holds between reads; the FIFO relies on that for its hold behaviour.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sc_param.sv
// Single-clock FIFO with exact registered flags, standard or FWFT read side.
// Defining FIFO_FLUSH_EN adds a synchronous flush input.
module fifo_sc_param
  import fifo_sc_param_pkg::*;
#(
  parameter int dta_width         = 8,
  parameter int addr_width        = 8,
  parameter int prog_full_thresh  = 1,
  parameter int prog_empty_thresh = 1,
  parameter int fwft              = 0
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef FIFO_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic [dta_width-1:0]  din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  prog_full,
  output logic [dta_width-1:0]  dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  valid,
  output logic                  underflow,
  output logic                  prog_empty,
  output logic [addr_width:0]   count
);

  localparam int CW    = cnt_width(addr_width);
  localparam int DEPTH = 1 << addr_width;

  logic clr;
`ifdef FIFO_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  logic                 hold;
  logic [CW-1:0]        wptr, rptr, cnt_next;
  logic                 wr_acc, rd_acc, ram_re;
  logic [dta_width-1:0] ram_q;

  assign hold     = rst | clr;
  assign wr_acc   = wr_en & ~full & ~hold;
  assign rd_acc   = rd_en & ~empty & ~hold;
  assign cnt_next = count + CW'(wr_acc) - CW'(rd_acc);

  // Flags come from cnt_next so they move in the same cycle as count.
  always_ff @(posedge clk) begin
    if (hold) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      full       <= 1'b0;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
    end else begin
      wptr       <= wptr + CW'(wr_acc);
      rptr       <= rptr + CW'(ram_re);
      count      <= cnt_next;
      full       <= (cnt_next == CW'(DEPTH));
      prog_full  <= ((DEPTH - int'(cnt_next)) <= prog_full_thresh);
      prog_empty <= (int'(cnt_next) <= prog_empty_thresh);
    end
  end

  // Handshake status reports the previous cycle; a flush cycle reports nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_acc;
      overflow  <= wr_en & ~wr_acc & ~clr;
      underflow <= rd_en & ~rd_acc & ~clr;
    end
  end

  fifo_sc_ram #(
    .dta_width (dta_width),
    .addr_width(addr_width)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wptr[addr_width-1:0]),
    .wdata(din),
    .re   (ram_re),
    .raddr(rptr[addr_width-1:0]),
    .rdata(ram_q)
  );

  if (fwft == FIFO_MODE_FWFT) begin : g_fwft
    // Two-stage prefetch: RAM read register (mid) feeding the visible output register.
    logic                 mid_vld, out_vld, move, issue;
    logic [dta_width-1:0] out_q;

    assign move  = mid_vld & (~out_vld | rd_acc);
    assign issue = (wptr != rptr) & (~mid_vld | move) & ~hold;
    assign ram_re = issue;

    always_ff @(posedge clk) begin
      if (rst) begin
        mid_vld <= 1'b0;
        out_vld <= 1'b0;
        out_q   <= '0;
      end else if (clr) begin
        mid_vld <= 1'b0;
        out_vld <= 1'b0;
      end else begin
        if (issue)     mid_vld <= 1'b1;
        else if (move) mid_vld <= 1'b0;
        if (move) begin
          out_vld <= 1'b1;
          out_q   <= ram_q;
        end else if (rd_acc) begin
          out_vld <= 1'b0;
        end
      end
    end

    assign empty = ~out_vld;
    assign valid = out_vld;
    assign dout  = out_q;
  end else begin : g_std
    // RAM read register is the output; dout_clr masks its unreset contents until the first read.
    logic empty_q, vld_q, dout_clr;

    assign ram_re = rd_acc;

    always_ff @(posedge clk) begin
      if (rst) begin
        empty_q  <= 1'b1;
        vld_q    <= 1'b0;
        dout_clr <= 1'b1;
      end else if (clr) begin
        empty_q  <= 1'b1;
        vld_q    <= 1'b0;
      end else begin
        empty_q <= (cnt_next == '0);
        vld_q   <= rd_acc;
        if (rd_acc) dout_clr <= 1'b0;
      end
    end

    assign empty = empty_q;
    assign valid = vld_q;
    assign dout  = dout_clr ? '0 : ram_q;
  end

endmodule

// File: tb/tb_fifo_sc_param.sv
// Bench for fifo_sc_param: standard (index 0) and FWFT (index 1) instances share stimulus,
// each checked every cycle against a queue model, plus literal spot checks.
`timescale 1ns/1ps
module tb_fifo_sc_param;

  localparam int AW = 2, DEPTH = 4, PFT = 1, PET = 1;

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] din = 8'h00;

  logic [1:0]        full_o, ack_o, ovf_o, pf_o, empty_o, vld_o, udf_o, pe_o;
  logic [1:0][7:0]   dout_o;
  logic [1:0][AW:0]  cnt_o;

  always #5 clk = ~clk;

  fifo_sc_param #(.dta_width(8), .addr_width(AW), .prog_full_thresh(PFT),
                  .prog_empty_thresh(PET), .fwft(0)) u_std (
    .clk(clk), .rst(rst),
`ifdef FIFO_FLUSH_EN
    .flush(flush),
`endif
    .din(din), .wr_en(wr_en), .full(full_o[0]), .wr_ack(ack_o[0]), .overflow(ovf_o[0]),
    .prog_full(pf_o[0]), .dout(dout_o[0]), .rd_en(rd_en), .empty(empty_o[0]),
    .valid(vld_o[0]), .underflow(udf_o[0]), .prog_empty(pe_o[0]), .count(cnt_o[0]));

  fifo_sc_param #(.dta_width(8), .addr_width(AW), .prog_full_thresh(PFT),
                  .prog_empty_thresh(PET), .fwft(1)) u_fwft (
    .clk(clk), .rst(rst),
`ifdef FIFO_FLUSH_EN
    .flush(flush),
`endif
    .din(din), .wr_en(wr_en), .full(full_o[1]), .wr_ack(ack_o[1]), .overflow(ovf_o[1]),
    .prog_full(pf_o[1]), .dout(dout_o[1]), .rd_en(rd_en), .empty(empty_o[1]),
    .valid(vld_o[1]), .underflow(udf_o[1]), .prog_empty(pe_o[1]), .count(cnt_o[1]));

  // ---------------- model ----------------
  typedef struct { logic [7:0] d; int wc; } wd_t;
  wd_t  q0[$], q1[$];
  wd_t  tmp;
  int   e = 0, last_pop = 0;
  logic [1:0] wa, ra, m_ack, m_ovf, m_udf;
  logic m_vld0;
  logic [7:0] m_dout0;
  logic flush_eff;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  function automatic int qsz(input int m);
    return (m == 0) ? q0.size() : q1.size();
  endfunction

  // FWFT head is shown two edges after its write, and no earlier than its predecessor's pop.
  function automatic bit vis1();
    return q1.size() > 0 && e >= q1[0].wc + 2 && e >= last_pop;
  endfunction

`ifdef FIFO_FLUSH_EN
  assign flush_eff = flush;
`else
  assign flush_eff = 1'b0;
`endif

  always @(posedge clk) begin
    wa[0] = wr_en && q0.size() != DEPTH && !flush_eff;
    wa[1] = wr_en && q1.size() != DEPTH && !flush_eff;
    ra[0] = rd_en && q0.size() != 0 && !flush_eff;
    ra[1] = rd_en && vis1() && !flush_eff;
    e++;
    if (rst) begin
      q0.delete(); q1.delete();
      m_ack = 0; m_ovf = 0; m_udf = 0; m_vld0 = 0; m_dout0 = 0; last_pop = 0;
    end else if (flush_eff) begin
      q0.delete(); q1.delete();
      m_ack = 0; m_ovf = 0; m_udf = 0; m_vld0 = 0;
    end else begin
      m_vld0 = ra[0];
      if (ra[0]) begin tmp = q0.pop_front(); m_dout0 = tmp.d; end
      if (ra[1]) begin tmp = q1.pop_front(); last_pop = e; end
      tmp.d = din; tmp.wc = e;
      if (wa[0]) q0.push_back(tmp);
      if (wa[1]) q1.push_back(tmp);
      m_ack = wa;
      m_ovf = {wr_en && !wa[1], wr_en && !wa[0]};
      m_udf = {rd_en && !ra[1], rd_en && !ra[0]};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("m%0d count", m), 32'(cnt_o[m]), qsz(m));
        chk($sformatf("m%0d full", m), 32'(full_o[m]), 32'(qsz(m) == DEPTH));
        chk($sformatf("m%0d empty", m), 32'(empty_o[m]),
            32'((m == 0) ? (q0.size() == 0) : !vis1()));
        chk($sformatf("m%0d prog_full", m), 32'(pf_o[m]), 32'((DEPTH - qsz(m)) <= PFT));
        chk($sformatf("m%0d prog_empty", m), 32'(pe_o[m]), 32'(qsz(m) <= PET));
        chk($sformatf("m%0d wr_ack", m), 32'(ack_o[m]), 32'(m_ack[m]));
        chk($sformatf("m%0d overflow", m), 32'(ovf_o[m]), 32'(m_ovf[m]));
        chk($sformatf("m%0d underflow", m), 32'(udf_o[m]), 32'(m_udf[m]));
        chk($sformatf("m%0d valid", m), 32'(vld_o[m]), 32'((m == 0) ? m_vld0 : vis1()));
      end
      chk("m0 dout", 32'(dout_o[0]), 32'(m_dout0));
      if (vis1()) chk("m1 dout", 32'(dout_o[1]), 32'(q1[0].d));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_en = w; din = d; rd_en = r;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; din = 8'hEE;
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk_en = 1'b1;
    chk("rst count", 32'(cnt_o[0]), 0);
    chk("rst empty", 32'(empty_o[0]), 1);
    chk("rst full", 32'(full_o[0]), 0);
    chk("rst prog_empty", 32'(pe_o[0]), 1);
    chk("rst prog_full", 32'(pf_o[0]), 0);
    chk("rst dout", 32'(dout_o[0]), 0);
    chk("rst valid", 32'(vld_o[0]), 0);
    chk("rst fwft dout", 32'(dout_o[1]), 0);
    chk("rst fwft empty", 32'(empty_o[1]), 1);

    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0);
    chk("cnt3 prog_full", 32'(pf_o[0]), 1);
    step(1, 8'h44, 0);
    chk("fill full", 32'(full_o[0]), 1);
    chk("fill count", 32'(cnt_o[0]), 4);
    chk("fill fwft full", 32'(full_o[1]), 1);
    step(1, 8'h55, 0);
    chk("ovf overflow", 32'(ovf_o[0]), 1);
    chk("ovf wr_ack", 32'(ack_o[0]), 0);
    chk("ovf count", 32'(cnt_o[0]), 4);

    step(1, 8'h66, 1);
    chk("full rw overflow", 32'(ovf_o[0]), 1);
    chk("full rw count", 32'(cnt_o[0]), 3);
    chk("full rw dout", 32'(dout_o[0]), 32'h11);
    chk("full rw fwft dout", 32'(dout_o[1]), 32'h22);
    step(0, 8'h00, 1); chk("drain dout 22", 32'(dout_o[0]), 32'h22);
    step(0, 8'h00, 1); chk("drain dout 33", 32'(dout_o[0]), 32'h33);
    step(0, 8'h00, 1); chk("drain dout 44", 32'(dout_o[0]), 32'h44);
    chk("drain valid", 32'(vld_o[0]), 1);
    chk("drain empty", 32'(empty_o[0]), 1);
    step(0, 8'h00, 1);
    chk("udf underflow", 32'(udf_o[0]), 1);
    chk("udf dout hold", 32'(dout_o[0]), 32'h44);

    step(1, 8'h77, 1);                       // edge N into empty FIFOs
    chk("empty rw underflow", 32'(udf_o[0]), 1);
    chk("empty rw wr_ack", 32'(ack_o[0]), 1);
    chk("empty rw count", 32'(cnt_o[0]), 1);
    step(0, 8'h00, 0);
    chk("fwft N+1 valid", 32'(vld_o[1]), 0);
    step(0, 8'h00, 0);
    chk("fwft N+2 valid", 32'(vld_o[1]), 1);
    chk("fwft N+2 dout", 32'(dout_o[1]), 32'h77);
    step(0, 8'h00, 1);
    chk("fwft pop valid", 32'(vld_o[1]), 0);
    chk("fwft pop count", 32'(cnt_o[1]), 0);
    chk("std pop dout", 32'(dout_o[0]), 32'h77);

    for (int i = 0; i < 20; i++) begin
      step(1, 8'(i), 0);
      step(0, 8'h00, 1);
      chk("wrap dout", 32'(dout_o[0]), i);
      chk("wrap count", 32'(cnt_o[0]), 0);
    end
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1);

    for (int i = 0; i < 80; i++) step((i % 3) != 2, 8'(i + 100), (i % 5) >= 2);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1);

    step(1, 8'hA1, 0); step(1, 8'hA2, 0); step(1, 8'hA3, 0);
    chk("pre-clear count", 32'(cnt_o[0]), 3);
    chk("pre-clear prog_full", 32'(pf_o[0]), 1);
`ifdef FIFO_FLUSH_EN
    flush = 1'b1;
    step(1, 8'hA4, 1);
    flush = 1'b0;
    chk("flush count", 32'(cnt_o[0]), 0);
    chk("flush empty", 32'(empty_o[0]), 1);
    chk("flush wr_ack", 32'(ack_o[0]), 0);
    chk("flush overflow", 32'(ovf_o[0]), 0);
    chk("flush underflow", 32'(udf_o[0]), 0);
    chk("flush fwft count", 32'(cnt_o[1]), 0);
`else
    rst = 1'b1;
    step(1, 8'hA4, 1);
    rst = 1'b0;
    chk("midrst count", 32'(cnt_o[0]), 0);
    chk("midrst empty", 32'(empty_o[0]), 1);
    chk("midrst fwft count", 32'(cnt_o[1]), 0);
`endif
    step(1, 8'hB1, 0);
    chk("cnt1 prog_empty", 32'(pe_o[0]), 1);
    chk("cnt1 count", 32'(cnt_o[0]), 1);
    step(0, 8'h00, 0); step(0, 8'h00, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
